// File: rtl/DEF.sv
// Shared types for the operand fetch stage: data word, register index and bypass source select.
`default_nettype none

package DEF;
  localparam int XLEN = 64;

  typedef logic [XLEN-1:0] dw;
  typedef logic [4:0]      reg_idx_t;

  typedef enum logic [2:0] {
    FWD_ZERO,
    FWD_EX,
    FWD_MEM,
    FWD_WB,
    FWD_RF
  } fwd_sel_t;
endpackage

`default_nettype wire

// File: rtl/operand_bypass.sv
// Priority bypass mux for one source operand: x0, then EX, MEM, WB, and finally the register file.
`default_nettype none

module operand_bypass
  import DEF::*;
#(
  parameter int XLEN = DEF::XLEN
) (
  input  reg_idx_t        idx_i,
  input  logic [XLEN-1:0] rf_data_i,
  input  logic            ex_valid_i,
  input  logic            ex_is_load_i,
  input  reg_idx_t        ex_rd_i,
  input  logic [XLEN-1:0] ex_data_i,
  input  logic            mem_valid_i,
  input  reg_idx_t        mem_rd_i,
  input  logic [XLEN-1:0] mem_data_i,
  input  logic            wb_w_en_i,
  input  reg_idx_t        wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic [XLEN-1:0] data_o
);

  fwd_sel_t sel;

  // A load in EX has no result yet; the hazard logic in the top stalls on it instead.
  always_comb begin
    sel = FWD_RF;
    if (idx_i == 5'd0)
      sel = FWD_ZERO;
    else if (ex_valid_i && !ex_is_load_i && (ex_rd_i == idx_i))
      sel = FWD_EX;
    else if (mem_valid_i && (mem_rd_i == idx_i))
      sel = FWD_MEM;
    else if (wb_w_en_i && (wb_rd_i == idx_i))
      sel = FWD_WB;
  end

  always_comb begin
    data_o = rf_data_i;
    case (sel)
      FWD_ZERO: data_o = '0;
      FWD_EX:   data_o = ex_data_i;
      FWD_MEM:  data_o = mem_data_i;
      FWD_WB:   data_o = wb_data_i;
      default:  data_o = rf_data_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/operand_fetch_stage.sv
// Decode-to-execute operand stage: register file read, RAW bypassing, load-use stall and
// a one-entry valid/ready output register feeding EX.
`default_nettype none

module operand_fetch_stage
  import DEF::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  reg_idx_t         in_rs1_index,
  input  reg_idx_t         in_rs2_index,
  input  reg_idx_t         in_rd_index,
  input  logic             in_uses_rs1,
  input  logic             in_uses_rs2,
  input  logic             in_is_load,
  input  logic             flush,
  output reg_idx_t         rf_rs1_index,
  output reg_idx_t         rf_rs2_index,
  input  logic [XLEN-1:0]  rf_rs1_data,
  input  logic [XLEN-1:0]  rf_rs2_data,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  reg_idx_t         ex_rd,
  input  logic [XLEN-1:0]  ex_data,
  input  logic             mem_valid,
  input  reg_idx_t         mem_rd,
  input  logic [XLEN-1:0]  mem_data,
  input  logic             wb_w_en,
  input  reg_idx_t         wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_rs1_data,
  output logic [XLEN-1:0]  out_rs2_data,
  output reg_idx_t         out_rd_index,
  output logic             out_is_load,
  output logic [CNT_W-1:0] stall_cycles
);

  logic             valid_q, valid_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  rs1_q, rs1_d;
  logic [XLEN-1:0]  rs2_q, rs2_d;
  reg_idx_t         rd_q, rd_d;
  logic             load_q, load_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic [XLEN-1:0]  rs1_res;
  logic [XLEN-1:0]  rs2_res;
  logic             hazard;
  logic             capture;

  assign rf_rs1_index = in_rs1_index;
  assign rf_rs2_index = in_rs2_index;

  operand_bypass #(.XLEN(XLEN)) u_bypass_rs1 (
    .idx_i        (in_rs1_index),
    .rf_data_i    (rf_rs1_data),
    .ex_valid_i   (ex_valid),
    .ex_is_load_i (ex_is_load),
    .ex_rd_i      (ex_rd),
    .ex_data_i    (ex_data),
    .mem_valid_i  (mem_valid),
    .mem_rd_i     (mem_rd),
    .mem_data_i   (mem_data),
    .wb_w_en_i    (wb_w_en),
    .wb_rd_i      (wb_rd),
    .wb_data_i    (wb_data),
    .data_o       (rs1_res)
  );

  operand_bypass #(.XLEN(XLEN)) u_bypass_rs2 (
    .idx_i        (in_rs2_index),
    .rf_data_i    (rf_rs2_data),
    .ex_valid_i   (ex_valid),
    .ex_is_load_i (ex_is_load),
    .ex_rd_i      (ex_rd),
    .ex_data_i    (ex_data),
    .mem_valid_i  (mem_valid),
    .mem_rd_i     (mem_rd),
    .mem_data_i   (mem_data),
    .wb_w_en_i    (wb_w_en),
    .wb_rd_i      (wb_rd),
    .wb_data_i    (wb_data),
    .data_o       (rs2_res)
  );

  // Only a load in EX that writes a register this instruction actually reads blocks it.
  assign hazard = in_valid && ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                  ((in_uses_rs1 && (ex_rd == in_rs1_index)) ||
                   (in_uses_rs2 && (ex_rd == in_rs2_index)));

  assign in_ready = !hazard && !flush && (!valid_q || out_ready);
  assign capture  = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    load_d  = load_q;
    stall_d = stall_q;

    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
      pc_d    = in_pc;
      rs1_d   = rs1_res;
      rs2_d   = rs2_res;
      rd_d    = in_rd_index;
      load_d  = in_is_load;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end

    if (hazard && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      load_q  <= 1'b0;
      stall_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      load_q  <= load_d;
      stall_q <= stall_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_pc       = pc_q;
  assign out_rs1_data = rs1_q;
  assign out_rs2_data = rs2_q;
  assign out_rd_index = rd_q;
  assign out_is_load  = load_q;
  assign stall_cycles = stall_q;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
`default_nettype none

module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid, in_uses_rs1, in_uses_rs2, in_is_load, flush;
  logic [63:0] in_pc, rf_rs1_data, rf_rs2_data, ex_data, mem_data, wb_data;
  logic [4:0]  in_rs1_index, in_rs2_index, in_rd_index, ex_rd, mem_rd, wb_rd;
  logic        ex_valid, ex_is_load, mem_valid, wb_w_en, out_ready;

  logic        in_ready, out_valid, out_is_load;
  logic [4:0]  rf_rs1_index, rf_rs2_index, out_rd_index;
  logic [63:0] out_pc, out_rs1_data, out_rs2_data;
  logic [31:0] stall_cycles;

  logic        s_in_ready, s_out_valid, s_out_is_load;
  logic [4:0]  s_rf_rs1_index, s_rf_rs2_index, s_out_rd_index;
  logic [63:0] s_out_pc, s_out_rs1_data, s_out_rs2_data;
  logic [1:0]  s_stall;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  logic        m_valid, m_load;
  logic [63:0] m_pc, m_rs1, m_rs2;
  logic [4:0]  m_rd;
  logic [31:0] m_cnt;
  logic [1:0]  m_cnt_s;
  logic        exp_haz, exp_ready, obs_ready;
  logic [4:0]  obs_rf1, obs_rf2;

  always #5 clk = ~clk;

  operand_fetch_stage #(.XLEN(64), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1_index(in_rs1_index), .in_rs2_index(in_rs2_index), .in_rd_index(in_rd_index),
    .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2), .in_is_load(in_is_load),
    .flush(flush), .rf_rs1_index(rf_rs1_index), .rf_rs2_index(rf_rs2_index),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .ex_valid(ex_valid),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_data(ex_data), .mem_valid(mem_valid),
    .mem_rd(mem_rd), .mem_data(mem_data), .wb_w_en(wb_w_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_rd_index(out_rd_index),
    .out_is_load(out_is_load), .stall_cycles(stall_cycles)
  );

  // Narrow-counter instance so saturation is reachable in a few cycles.
  operand_fetch_stage #(.XLEN(64), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_pc(in_pc),
    .in_rs1_index(in_rs1_index), .in_rs2_index(in_rs2_index), .in_rd_index(in_rd_index),
    .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2), .in_is_load(in_is_load),
    .flush(flush), .rf_rs1_index(s_rf_rs1_index), .rf_rs2_index(s_rf_rs2_index),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .ex_valid(ex_valid),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_data(ex_data), .mem_valid(mem_valid),
    .mem_rd(mem_rd), .mem_data(mem_data), .wb_w_en(wb_w_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .out_valid(s_out_valid), .out_ready(out_ready), .out_pc(s_out_pc),
    .out_rs1_data(s_out_rs1_data), .out_rs2_data(s_out_rs2_data),
    .out_rd_index(s_out_rd_index), .out_is_load(s_out_is_load), .stall_cycles(s_stall)
  );

  function automatic logic [63:0] resolve(input logic [4:0] idx, input logic [63:0] rfd);
    if (idx == 5'd0) return 64'd0;
    if (ex_valid && !ex_is_load && ex_rd == idx) return ex_data;
    if (mem_valid && mem_rd == idx) return mem_data;
    if (wb_w_en && wb_rd == idx) return wb_data;
    return rfd;
  endfunction

  task automatic clear_inputs();
    in_valid = 0; in_uses_rs1 = 0; in_uses_rs2 = 0; in_is_load = 0; flush = 0;
    in_pc = 0; rf_rs1_data = 0; rf_rs2_data = 0; ex_data = 0; mem_data = 0; wb_data = 0;
    in_rs1_index = 0; in_rs2_index = 0; in_rd_index = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
    ex_valid = 0; ex_is_load = 0; mem_valid = 0; wb_w_en = 0; out_ready = 1;
  endtask

  task automatic model_reset();
    m_valid = 0; m_load = 0; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_cnt = 0; m_cnt_s = 0;
  endtask

  // Advance one clock: sample the combinational outputs, then update the model at the edge.
  task automatic step();
    logic        cap;
    logic [63:0] n1, n2;
    #1;
    exp_haz   = in_valid && ex_valid && ex_is_load && (ex_rd != 0) &&
                ((in_uses_rs1 && ex_rd == in_rs1_index) || (in_uses_rs2 && ex_rd == in_rs2_index));
    exp_ready = !exp_haz && !flush && (!m_valid || out_ready);
    obs_ready = in_ready;
    obs_rf1   = rf_rs1_index;
    obs_rf2   = rf_rs2_index;
    cap = in_valid && exp_ready;
    n1  = resolve(in_rs1_index, rf_rs1_data);
    n2  = resolve(in_rs2_index, rf_rs2_data);
    @(posedge clk);
    if (flush) m_valid = 0;
    else if (cap) begin
      m_valid = 1; m_pc = in_pc; m_rs1 = n1; m_rs2 = n2; m_rd = in_rd_index; m_load = in_is_load;
    end else if (out_ready) m_valid = 0;
    if (exp_haz && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (exp_haz && m_cnt_s != 2'd3) m_cnt_s = m_cnt_s + 1;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    model_reset();
    rst = 0;
    repeat (2) @(posedge clk);
    #2;
    n_cmp++;
    if (out_valid !== 0 || out_pc !== 0 || out_rs1_data !== 0 || out_rs2_data !== 0 ||
        out_rd_index !== 0 || out_is_load !== 0 || stall_cycles !== 0) begin
      n_fail++;
      $display("FAIL reset: valid=%0b pc=%h rs1=%h rs2=%h rd=%0d ld=%0b cnt=%0d required all zero",
               out_valid, out_pc, out_rs1_data, out_rs2_data, out_rd_index, out_is_load, stall_cycles);
    end
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    clear_inputs();
    in_valid = 1; in_uses_rs1 = 1; in_uses_rs2 = 1; in_rs1_index = 5; in_rs2_index = 6;
    in_rd_index = 9; in_pc = 64'h1000; rf_rs1_data = 64'h11; rf_rs2_data = 64'h22;
    step();
    n_cmp++;
    if (obs_ready !== 1'b1 || obs_rf1 !== 5'd5 || obs_rf2 !== 5'd6) begin
      n_fail++;
      $display("FAIL basic_comb: ready=%0b rf1=%0d rf2=%0d required 1/5/6", obs_ready, obs_rf1, obs_rf2);
    end
    n_cmp++;
    if (out_valid !== 1'b1 || out_rs1_data !== 64'h11 || out_rs2_data !== 64'h22 ||
        out_pc !== 64'h1000 || out_rd_index !== 5'd9) begin
      n_fail++;
      $display("FAIL basic_capture: valid=%0b rs1=%h rs2=%h pc=%h rd=%0d required 1/11/22/1000/9",
               out_valid, out_rs1_data, out_rs2_data, out_pc, out_rd_index);
    end
  endtask

  task automatic test_ex_priority();
    ex_valid = 1; ex_rd = 5; ex_data = 64'hAA; mem_valid = 1; mem_rd = 5; mem_data = 64'hBB;
    step();
    n_cmp++;
    if (out_rs1_data !== 64'hAA) begin
      n_fail++;
      $display("FAIL ex_priority: rs1=%h required aa", out_rs1_data);
    end
    ex_valid = 0;
    step();
    n_cmp++;
    if (out_rs1_data !== 64'hBB) begin
      n_fail++;
      $display("FAIL mem_forward: rs1=%h required bb", out_rs1_data);
    end
  endtask

  task automatic test_wb_and_x0();
    clear_inputs();
    in_valid = 1; in_uses_rs1 = 1; in_uses_rs2 = 1; in_rs1_index = 0; in_rs2_index = 7;
    wb_w_en = 1; wb_rd = 7; wb_data = 64'hCAFE; rf_rs2_data = 64'h0;
    ex_valid = 1; ex_rd = 0; ex_data = 64'h99; rf_rs1_data = 64'h77;
    step();
    n_cmp++;
    if (out_rs2_data !== 64'hCAFE) begin
      n_fail++;
      $display("FAIL wb_forward: rs2=%h required cafe", out_rs2_data);
    end
    n_cmp++;
    if (out_rs1_data !== 64'h0) begin
      n_fail++;
      $display("FAIL x0_zero: rs1=%h required 0", out_rs1_data);
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    in_valid = 1; in_uses_rs1 = 1; in_uses_rs2 = 1; in_rs1_index = 5; in_rs2_index = 3;
    ex_valid = 1; ex_is_load = 1; ex_rd = 3; ex_data = 64'hDEAD;
    step();
    n_cmp++;
    if (obs_ready !== 1'b0 || out_valid !== 1'b0 || stall_cycles !== 32'd1) begin
      n_fail++;
      $display("FAIL load_use_stall: ready=%0b valid=%0b cnt=%0d required 0/0/1",
               obs_ready, out_valid, stall_cycles);
    end
    ex_valid = 0; mem_valid = 1; mem_rd = 3; mem_data = 64'h55;
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_rs2_data !== 64'h55 || stall_cycles !== 32'd1) begin
      n_fail++;
      $display("FAIL load_use_release: valid=%0b rs2=%h cnt=%0d required 1/55/1",
               out_valid, out_rs2_data, stall_cycles);
    end
    ex_valid = 1; in_uses_rs2 = 0;
    step();
    n_cmp++;
    if (obs_ready !== 1'b1 || out_valid !== 1'b1 || out_rs2_data !== 64'h55 || stall_cycles !== 32'd1) begin
      n_fail++;
      $display("FAIL unused_no_stall: ready=%0b valid=%0b rs2=%h cnt=%0d required 1/1/55/1",
               obs_ready, out_valid, out_rs2_data, stall_cycles);
    end
  endtask

  task automatic test_backpressure();
    clear_inputs();
    in_valid = 1; in_uses_rs1 = 1; in_rs1_index = 9; rf_rs1_data = 64'h1234; in_pc = 64'h2000;
    step();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      rf_rs1_data = 64'h5000 + 64'(i); in_pc = 64'h3000 + 64'(i);
      step();
      n_cmp++;
      if (obs_ready !== 1'b0 || out_valid !== 1'b1 || out_rs1_data !== 64'h1234 || out_pc !== 64'h2000) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: ready=%0b valid=%0b rs1=%h pc=%h required 0/1/1234/2000",
                 i, obs_ready, out_valid, out_rs1_data, out_pc);
      end
    end
    flush = 1;
    step();
    n_cmp++;
    if (obs_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush: ready=%0b valid=%0b required 0/0", obs_ready, out_valid);
    end
    flush = 0; out_ready = 1;
  endtask

  task automatic test_saturation();
    clear_inputs();
    in_valid = 1; in_uses_rs1 = 1; in_rs1_index = 4; ex_valid = 1; ex_is_load = 1; ex_rd = 4;
    flush = 1;
    step();
    flush = 0;
    step();
    step();
    n_cmp++;
    if (s_stall !== 2'd3 || stall_cycles !== 32'd4) begin
      n_fail++;
      $display("FAIL counter_saturate: small=%0d wide=%0d required 3/4", s_stall, stall_cycles);
    end
    step();
    n_cmp++;
    if (s_stall !== 2'd3 || stall_cycles !== 32'd5 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL counter_no_wrap: small=%0d wide=%0d valid=%0b required 3/5/0",
               s_stall, stall_cycles, out_valid);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_uses_rs1 = 1'($urandom); in_uses_rs2 = 1'($urandom); in_is_load = 1'($urandom);
      flush = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_pc = {$urandom, $urandom};
      in_rs1_index = 5'($urandom_range(0, 7)); in_rs2_index = 5'($urandom_range(0, 7));
      in_rd_index = 5'($urandom);
      rf_rs1_data = {$urandom, $urandom}; rf_rs2_data = {$urandom, $urandom};
      ex_valid = 1'($urandom); ex_is_load = ($urandom_range(0, 2) == 0);
      ex_rd = 5'($urandom_range(0, 7)); ex_data = {$urandom, $urandom};
      mem_valid = 1'($urandom); mem_rd = 5'($urandom_range(0, 7)); mem_data = {$urandom, $urandom};
      wb_w_en = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_data = {$urandom, $urandom};
      step();
      n_cmp++;
      if (obs_ready !== exp_ready || obs_rf1 !== in_rs1_index || obs_rf2 !== in_rs2_index) begin
        n_fail++;
        $display("FAIL rand_comb[%0d]: ready=%0b rf1=%0d rf2=%0d required %0b/%0d/%0d",
                 c, obs_ready, obs_rf1, obs_rf2, exp_ready, in_rs1_index, in_rs2_index);
      end
      n_cmp++;
      if (out_valid !== m_valid || stall_cycles !== m_cnt || s_stall !== m_cnt_s) begin
        n_fail++;
        $display("FAIL rand_ctrl[%0d]: valid=%0b cnt=%0d small=%0d required %0b/%0d/%0d",
                 c, out_valid, stall_cycles, s_stall, m_valid, m_cnt, m_cnt_s);
      end
      if (m_valid) begin
        n_cmp++;
        if (out_pc !== m_pc || out_rs1_data !== m_rs1 || out_rs2_data !== m_rs2 ||
            out_rd_index !== m_rd || out_is_load !== m_load) begin
          n_fail++;
          $display("FAIL rand_data[%0d]: pc=%h rs1=%h rs2=%h rd=%0d ld=%0b required %h/%h/%h/%0d/%0b",
                   c, out_pc, out_rs1_data, out_rs2_data, out_rd_index, out_is_load,
                   m_pc, m_rs1, m_rs2, m_rd, m_load);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    clear_inputs();
    in_valid = 1; in_rs1_index = 2; rf_rs1_data = 64'hF00D; in_pc = 64'h4444;
    ex_valid = 1; ex_is_load = 1; ex_rd = 2; in_uses_rs1 = 1;
    step();
    in_uses_rs1 = 0;
    step();
    #2;
    rst = 0;
    #1;
    n_cmp++;
    if (out_valid !== 0 || out_pc !== 0 || out_rs1_data !== 0 || out_rs2_data !== 0 ||
        out_rd_index !== 0 || out_is_load !== 0 || stall_cycles !== 0 || s_stall !== 0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%0b pc=%h rs1=%h cnt=%0d small=%0d required all zero",
               out_valid, out_pc, out_rs1_data, stall_cycles, s_stall);
    end
    model_reset();
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ex_priority();
    test_wb_and_x0();
    test_load_use();
    test_backpressure();
    test_saturation();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode→execute operand stage of the RV64I pipeline.
- Drives the register file read indices and takes its combinational read data.
- Resolves RAW hazards by bypassing from EX, MEM and WB, and stalls one cycle on load-use.
- Registers the operands into a one-entry valid/ready pipeline register that feeds EX.

Parameters:
- XLEN, 64, data width; equals width of DEF::dw.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  decoded instruction valid
- in_ready  out  1  stage can accept the instruction
- in_pc  in  64  instruction PC
- in_rs1_index  in  5  source 1 index
- in_rs2_index  in  5  source 2 index
- in_rd_index  in  5  destination index
- in_uses_rs1  in  1  instruction reads rs1
- in_uses_rs2  in  1  instruction reads rs2
- in_is_load  in  1  instruction is a load
- flush  in  1  kill the held instruction and refuse capture this cycle
- rf_rs1_index  out  5  register file read index 1
- rf_rs2_index  out  5  register file read index 2
- rf_rs1_data  in  64  register file read data 1
- rf_rs2_data  in  64  register file read data 2
- ex_valid, ex_is_load  in  1 each  EX-stage instruction valid / is a load
- ex_rd  in  5  EX destination index
- ex_data  in  64  EX result
- mem_valid  in  1  MEM-stage result valid
- mem_rd  in  5  MEM destination index
- mem_data  in  64  MEM result
- wb_w_en  in  1  WB write enable (same signal as register file w_en)
- wb_rd  in  5  WB destination index
- wb_data  in  64  WB write data
- out_valid  out  1  operands valid to EX
- out_ready  in  1  EX accepts
- out_pc  out  64  registered PC
- out_rs1_data, out_rs2_data  out  64 each  registered resolved operands
- out_rd_index  out  5  registered destination index
- out_is_load  out  1  registered load flag
- stall_cycles  out  CNT_W  load-use stall counter

Behaviour:
- Reset: rst asynchronous, active-low; clock clk. While rst=0, every registered output (out_*, stall_cycles) is 0.
- rf_rsN_index = in_rsN_index, combinational.
- Operand resolution, per source N, priority top to bottom:
  - index==0 → 0. Never forwarded.
  - ex_valid && !ex_is_load && ex_rd==idx → ex_data.
  - mem_valid && mem_rd==idx → mem_data.
  - wb_w_en && wb_rd==idx → wb_data. Covers the register-file write-then-read cycle.
  - Otherwise → rf_rsN_data.
- hazard = in_valid && ex_valid && ex_is_load && ex_rd!=0 && ((in_uses_rs1 && ex_rd==in_rs1_index) || (in_uses_rs2 && ex_rd==in_rs2_index)).
- in_ready = !hazard && !flush && (!out_valid || out_ready). Combinational, no dependence on in_valid other than through hazard.
- Capture when in_valid && in_ready: the out_* registers load the next cycle. Latency is 1 cycle.
- If out_valid && out_ready and no capture, out_valid→0 (bubble). On a hazard cycle EX therefore sees a bubble.
- If out_valid && !out_ready, all out_* hold unchanged; held operands are not re-resolved.
- flush has priority: next cycle out_valid=0, no capture, and data registers may hold stale values.
- Simultaneous hazard and flush: flush wins; the counter still counts the hazard.
- stall_cycles increments by 1 on every cycle with hazard=1 and saturates at 2^CNT_W-1 with no wrap. It is cleared only by reset.
- Operands not used (in_uses_rsN=0) are still resolved and registered; they never cause a hazard.

Decomposition:
- Package DEF: dw (XLEN-bit word), XLEN, reg_idx_t (logic [4:0]), enum fwd_sel_t {FWD_ZERO, FWD_EX, FWD_MEM, FWD_WB, FWD_RF}.
- Sub-module operand_bypass: combinational priority mux for one operand. Instantiated twice, rs1 and rs2.
- Pipeline register, handshake, hazard logic and counter live in the top.

Test Plan:
- Reset, then in_valid=1, rs1=5, rs2=6, rf data 0x11/0x22, no forwarding → next cycle out_valid=1, out_rs1_data=0x11, out_rs2_data=0x22.
- ex_valid=1, ex_rd=5, ex_data=0xAA and mem_valid=1, mem_rd=5, mem_data=0xBB, rs1=5 → out_rs1_data=0xAA (EX priority). Repeat with ex_valid=0 → 0xBB.
- wb_w_en=1, wb_rd=7, wb_data=0xCAFE, rf_rs2_data=0 stale, rs2=7 → out_rs2_data=0xCAFE. Same with rs1=0 and ex_rd=0, ex_data=0x99 → out_rs1_data=0.
- ex_is_load=1, ex_rd=3, in_uses_rs2=1, rs2=3 → in_ready=0 for that cycle, out_valid=0 next cycle, stall_cycles=1. Drop ex_valid and mem_rd=3, mem_data=0x55 → captured, out_rs2_data=0x55. Repeat with in_uses_rs2=0 → no stall.
- out_ready=0 for 3 cycles with out_valid=1 → in_ready=0 and out_* stable all 3 cycles. Assert flush → next cycle out_valid=0.
- Force counter to 0xFFFFFFFE with 3 hazard cycles → ends at 0xFFFFFFFF. Assert rst mid-operation → all outputs 0 immediately (asynchronous).
